// File: rtl/uart_cmd_parser.sv
// Assembles 14-byte command frames from uart_rx bytes, checks CRC-8 and footer, strobes results.
// Optional inter-byte timeout is built only when PARSER_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | hunting for HEADER, other bytes dropped
// PAYLOAD | shifting 11 payload bytes into shadow and CRC
// CHECK   | comparing received CRC byte against running CRC
// TAIL    | checking footer, issuing cmd_valid / crc_err / frame_err
module uart_cmd_parser #(
  parameter logic [7:0]  HEADER      = 8'h55,
  parameter logic [7:0]  FOOTER      = 8'hAA,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic        cmd_valid,
  output logic [7:0]  reg_func,
  output logic [7:0]  hs_pwm_ch,
  output logic [7:0]  hs_ctrl_sta,
  output logic [7:0]  duty_num,
  output logic [15:0] pulse_dessert,
  output logic [7:0]  pulse_num,
  output logic [31:0] pattern,
  output logic        crc_err,
  output logic        frame_err,
  output logic        timeout_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, TAIL} state_t;

  state_t      state, state_nxt;
  logic [3:0]  byte_cnt;
  logic [7:0]  crc;
  logic        crc_ok;
  logic [87:0] shadow;
  logic        timeout_hit;
  logic        tail_hit;
  logic        accept_good;
  logic        accept_crc_bad;
  logic        accept_frm_bad;

  // Polynomial 0x07, MSB-first, no reflection; one byte per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
    end
    return r;
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (timeout_hit) begin
      state_nxt = IDLE;
    end else if (rx_done) begin
      case (state)
        IDLE:    if (rx_data == HEADER) state_nxt = PAYLOAD;
        PAYLOAD: if (byte_cnt == 4'd10) state_nxt = CHECK;
        CHECK:   state_nxt = TAIL;
        TAIL:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state != IDLE);
    tail_hit       = (state == TAIL) && rx_done;
    accept_frm_bad = tail_hit && (rx_data != FOOTER);
    accept_crc_bad = tail_hit && (rx_data == FOOTER) && !crc_ok;
    accept_good    = tail_hit && (rx_data == FOOTER) && crc_ok;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      byte_cnt      <= 4'd0;
      crc           <= 8'h00;
      crc_ok        <= 1'b0;
      shadow        <= '0;
      cmd_valid     <= 1'b0;
      crc_err       <= 1'b0;
      frame_err     <= 1'b0;
      reg_func      <= 8'h00;
      hs_pwm_ch     <= 8'h00;
      hs_ctrl_sta   <= 8'h00;
      duty_num      <= 8'h00;
      pulse_dessert <= 16'h0000;
      pulse_num     <= 8'h00;
      pattern       <= 32'h0;
    end else begin
      cmd_valid <= accept_good;
      crc_err   <= accept_crc_bad;
      frame_err <= accept_frm_bad;
      if (rx_done) begin
        case (state)
          IDLE: begin
            if (rx_data == HEADER) begin
              byte_cnt <= 4'd0;
              crc      <= 8'h00;
            end
          end
          PAYLOAD: begin
            shadow   <= {shadow[79:0], rx_data};
            crc      <= crc8_step(crc, rx_data);
            byte_cnt <= byte_cnt + 4'd1;
          end
          CHECK:   crc_ok <= (rx_data == crc);
          default: ;
        endcase
      end
      // Fields only move on a fully validated frame.
      if (accept_good) begin
        reg_func      <= shadow[87:80];
        hs_pwm_ch     <= shadow[79:72];
        hs_ctrl_sta   <= shadow[71:64];
        duty_num      <= shadow[63:56];
        pulse_dessert <= shadow[55:40];
        pulse_num     <= shadow[39:32];
        pattern       <= shadow[31:0];
      end
    end
  end

`ifdef PARSER_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYC - 1);

  logic [TMR_W-1:0] idle_tmr;

  // Down-counter reloads on every byte; a coincident byte always beats expiry.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      idle_tmr    <= TMR_LOAD;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= timeout_hit;
      if ((state == IDLE) || rx_done || timeout_hit) idle_tmr <= TMR_LOAD;
      else                                           idle_tmr <= idle_tmr - TMR_W'(1);
    end
  end

  assign timeout_hit = (state != IDLE) && !rx_done && (idle_tmr == '0);
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed-frame bench for uart_cmd_parser; frame CRCs are precomputed by hand.
// Define PARSER_TIMEOUT_EN to also exercise the inter-byte timeout with TIMEOUT_CYC=100.
module tb_uart_cmd_parser;

`ifdef PARSER_TIMEOUT_EN
  localparam int unsigned TB_TIMEOUT = 100;
`else
  localparam int unsigned TB_TIMEOUT = 50000;
`endif

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [7:0]  rx_data;
  logic        rx_done;
  logic        cmd_valid;
  logic [7:0]  reg_func;
  logic [7:0]  hs_pwm_ch;
  logic [7:0]  hs_ctrl_sta;
  logic [7:0]  duty_num;
  logic [15:0] pulse_dessert;
  logic [7:0]  pulse_num;
  logic [31:0] pattern;
  logic        crc_err;
  logic        frame_err;
  logic        timeout_err;
  logic        busy;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int n_crc   = 0;
  int n_frm   = 0;
  int n_to    = 0;
  int n_multi = 0;

  uart_cmd_parser #(.TIMEOUT_CYC(TB_TIMEOUT)) dut (
    .sys_clk       (sys_clk),
    .sys_rst       (sys_rst),
    .rx_data       (rx_data),
    .rx_done       (rx_done),
    .cmd_valid     (cmd_valid),
    .reg_func      (reg_func),
    .hs_pwm_ch     (hs_pwm_ch),
    .hs_ctrl_sta   (hs_ctrl_sta),
    .duty_num      (duty_num),
    .pulse_dessert (pulse_dessert),
    .pulse_num     (pulse_num),
    .pattern       (pattern),
    .crc_err       (crc_err),
    .frame_err     (frame_err),
    .timeout_err   (timeout_err),
    .busy          (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Pulse counters sampled mid-cycle, clear of both clock edges.
  always @(posedge sys_clk) begin
    #2;
    if (cmd_valid)   n_valid++;
    if (crc_err)     n_crc++;
    if (frame_err)   n_frm++;
    if (timeout_err) n_to++;
    if (({3'b0, cmd_valid} + {3'b0, crc_err} + {3'b0, frame_err} + {3'b0, timeout_err}) > 4'd1)
      n_multi++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [111:0] mk(input logic [87:0] p, input logic [7:0] c, input logic [7:0] f);
    return {8'h55, p, c, f};
  endfunction

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge sys_clk);
    rx_data = b;
    rx_done = 1'b1;
    if (gap > 0) begin
      @(negedge sys_clk);
      rx_done = 1'b0;
      repeat (gap - 1) @(negedge sys_clk);
    end
  endtask

  task automatic send_frame(input logic [111:0] fr, input int gap);
    for (int i = 0; i < 14; i++) send_byte(fr[111 - 8*i -: 8], gap);
  endtask

  task automatic settle();
    @(negedge sys_clk);
    rx_done = 1'b0;
    repeat (3) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst = 1'b1;
    rx_done = 1'b0;
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
  endtask

  logic [111:0] f1, f2, f3, f4, f5, f6, f7;
  int b_valid, b_crc, b_frm;
  logic seen;
  int cyc;

  initial begin
    f1 = mk(88'h01_02_00_01_00_01_00_00_00_00_01, 8'hF2, 8'hAA);
    f2 = mk(88'h02_01_01_00_00_00_00_00_00_00_00, 8'h2F, 8'hAA);
    f3 = mk(88'h02_01_00_00_00_00_00_00_00_00_00, 8'h55, 8'hAA);
    f4 = mk(88'h02_03_00_00_00_00_00_00_00_00_00, 8'h86, 8'hA5);
    f5 = mk(88'h02_02_00_00_00_00_00_00_00_00_00, 8'hEE, 8'hAA);
    f6 = mk(88'h02_02_01_00_00_00_00_00_00_00_00, 8'h97, 8'hAA);
    f7 = mk(88'h02_03_01_00_00_00_00_00_00_00_00, 8'hFF, 8'hAA);

    sys_rst = 1'b1;
    rx_done = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check("rst_busy",      busy,          1'b0);
    check("rst_valid",     cmd_valid,     1'b0);
    check("rst_reg_func",  reg_func,      8'h00);
    check("rst_pd",        pulse_dessert, 16'h0000);
    check("rst_pattern",   pattern,       32'h0);

    // Good frame; footer strobe must produce cmd_valid on the next cycle.
    b_valid = n_valid;
    for (int i = 0; i < 13; i++) send_byte(f1[111 - 8*i -: 8], 1);
    check("f1_busy_mid", busy, 1'b1);
    send_byte(8'hAA, 0);
    @(negedge sys_clk);
    rx_done = 1'b0;
    check("f1_latency",  cmd_valid, 1'b1);
    check("f1_idle",     busy,      1'b0);
    settle();
    check("f1_count",    n_valid - b_valid, 1);
    check("f1_reg_func", reg_func,      8'h01);
    check("f1_ch",       hs_pwm_ch,     8'h02);
    check("f1_ctrl",     hs_ctrl_sta,   8'h00);
    check("f1_duty",     duty_num,      8'h01);
    check("f1_pd",       pulse_dessert, 16'h0001);
    check("f1_pnum",     pulse_num,     8'h00);
    check("f1_pattern",  pattern,       32'h0000_0001);

    // Good frame then a CRC-corrupted one.
    b_valid = n_valid; b_crc = n_crc;
    send_frame(f2, 1); settle();
    check("f2_count", n_valid - b_valid, 1);
    check("f2_ctrl",  hs_ctrl_sta, 8'h01);
    check("f2_func",  reg_func,    8'h02);
    send_frame(f3, 1); settle();
    check("f3_crc_err",  n_crc - b_crc,     1);
    check("f3_no_valid", n_valid - b_valid, 1);
    check("f3_ctrl_hold", hs_ctrl_sta, 8'h01);

    // Bad footer then good frame.
    b_valid = n_valid; b_frm = n_frm; b_crc = n_crc;
    send_frame(f4, 1); settle();
    check("f4_frame_err", n_frm - b_frm,     1);
    check("f4_no_valid",  n_valid - b_valid, 0);
    check("f4_no_crc",    n_crc - b_crc,     0);
    check("f4_ch_hold",   hs_pwm_ch, 8'h01);
    send_frame(f5, 1); settle();
    check("f5_count", n_valid - b_valid, 1);
    check("f5_ch",    hs_pwm_ch,   8'h02);
    check("f5_ctrl",  hs_ctrl_sta, 8'h00);

    // Junk in IDLE is dropped silently.
    b_valid = n_valid; b_frm = n_frm; b_crc = n_crc;
    send_byte(8'h00, 1); send_byte(8'hFF, 1); send_byte(8'h12, 1);
    check("junk_idle", busy, 1'b0);
    send_frame(f6, 1); settle();
    check("f6_count", n_valid - b_valid, 1);
    check("f6_errs",  (n_frm - b_frm) + (n_crc - b_crc), 0);
    check("f6_ctrl",  hs_ctrl_sta, 8'h01);

    // Reset in the middle of a frame.
    b_frm = n_frm; b_crc = n_crc;
    for (int i = 0; i < 6; i++) send_byte(f7[111 - 8*i -: 8], 1);
    do_reset();
    check("mid_rst_busy", busy,        1'b0);
    check("mid_rst_ctrl", hs_ctrl_sta, 8'h00);
    b_valid = n_valid;
    send_frame(f1, 1); settle();
    check("mid_rst_count",   n_valid - b_valid, 1);
    check("mid_rst_errs",    (n_frm - b_frm) + (n_crc - b_crc), 0);
    check("mid_rst_pattern", pattern, 32'h0000_0001);

    // Back-to-back frames with no idle cycle between footer and next header.
    b_valid = n_valid;
    send_frame(f2, 0);
    send_frame(f5, 0);
    settle();
    check("b2b_count", n_valid - b_valid, 2);
    check("b2b_ch",    hs_pwm_ch,   8'h02);
    check("b2b_ctrl",  hs_ctrl_sta, 8'h00);

    // Stalled partial frame.
    send_byte(8'h55, 1);
    send_byte(8'h02, 1);
    seen = 1'b0;
    cyc  = 0;
`ifdef PARSER_TIMEOUT_EN
    for (int i = 0; i < 150 && !seen; i++) begin
      @(negedge sys_clk);
      if (timeout_err) begin
        seen = 1'b1;
        cyc  = i + 1;
      end
    end
    check("to_pulse",   seen, 1'b1);
    check("to_latency", cyc,  100);
    check("to_busy",    busy, 1'b0);
    b_valid = n_valid;
    send_frame(f7, 1); settle();
    check("to_recover", n_valid - b_valid, 1);
    check("to_ch",      hs_pwm_ch, 8'h03);
    check("to_count",   n_to, 1);
`else
    repeat (200) @(negedge sys_clk);
    check("stall_busy", busy,  1'b1);
    check("stall_no_to", n_to, 0);
    do_reset();
    b_valid = n_valid;
    send_frame(f7, 1); settle();
    check("stall_recover", n_valid - b_valid, 1);
    check("stall_ch",      hs_pwm_ch, 8'h03);
`endif

    check("one_hot", n_multi, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
